// File: rtl/des_iter_core.sv
// Iterative DES engine: IP, 16 Feistel rounds (RPC per clock), swap, IP^-1.
// Forward or reverse key schedule is computed on the fly from C/D.

package des_pkg;
    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6,
                                 64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30,
                                 37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                  19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                  14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                  41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    // Each S-box is 64 nibbles in row-major order (row = outer bits, col = inner bits), first entry at MSB
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    // Tables use DES numbering: bit 1 is the MSB of the vector
    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] y;
        logic [5:0]  b;
        logic [7:0]  pos;
        for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
        x = x ^ k;
        for (int i = 0; i < 8; i++) begin
            b   = x[47-6*i -: 6];
            pos = 8'd255 - {b[5], b[0], b[4:1], 2'b00};
            s[31-4*i -: 4] = SBOX[i][pos -: 4];
        end
        for (int i = 0; i < 32; i++) y[31-i] = s[32-P_T[i]];
        return y;
    endfunction
endpackage

// One Feistel round plus the matching C/D rotation for round number rnd (1..16)
module des_round import des_pkg::*; (
    input  logic [31:0] l,
    input  logic [31:0] r,
    input  logic [27:0] c,
    input  logic [27:0] d,
    input  logic [4:0]  rnd,
    input  logic        dec,
    output logic [31:0] nl,
    output logic [31:0] nr,
    output logic [27:0] nc,
    output logic [27:0] nd
);
    logic one;

    // Encrypt rotates left before use; decrypt walks back with right rotations, round 1 unrotated
    always_comb begin
        one = 1'b0;
        nc  = c;
        nd  = d;
        if (!dec) begin
            one = (rnd == 5'd1) || (rnd == 5'd2) || (rnd == 5'd9) || (rnd == 5'd16);
            nc  = one ? {c[26:0], c[27]} : {c[25:0], c[27:26]};
            nd  = one ? {d[26:0], d[27]} : {d[25:0], d[27:26]};
        end else if (rnd != 5'd1) begin
            one = (rnd == 5'd2) || (rnd == 5'd9) || (rnd == 5'd16);
            nc  = one ? {c[0], c[27:1]} : {c[1:0], c[27:2]};
            nd  = one ? {d[0], d[27:1]} : {d[1:0], d[27:2]};
        end
    end

    assign nl = r;
    assign nr = l ^ feistel(r, perm_pc2({nc, nd}));
endmodule

module des_iter_core import des_pkg::*; #(
    parameter int RPC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [63:0] key,
    input  logic        decrypt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy
);
    localparam int NITER = 16 / RPC;

    if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8 || RPC == 16)) begin : g_bad_rpc
        $error("des_iter_core: RPC must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
    state_t state, state_nx;

    logic [31:0] l_q, r_q;
    logic [27:0] c_q, d_q;
    logic [3:0]  cnt;
    logic        dec_q;
    logic        last;

    // Unrolled round chain: stage j evaluates round cnt*RPC+j+1
    for (genvar j = 0; j < RPC; j++) begin : g_rnd
        logic [31:0] l_s, r_s, l_n, r_n;
        logic [27:0] c_s, d_s, c_n, d_n;
        logic [4:0]  rnd;
        if (j == 0) begin : g_head
            assign l_s = l_q;
            assign r_s = r_q;
            assign c_s = c_q;
            assign d_s = d_q;
        end else begin : g_link
            assign l_s = g_rnd[j-1].l_n;
            assign r_s = g_rnd[j-1].r_n;
            assign c_s = g_rnd[j-1].c_n;
            assign d_s = g_rnd[j-1].d_n;
        end
        assign rnd = 5'(int'(cnt) * RPC + j + 1);
        des_round u_round (
            .l(l_s), .r(r_s), .c(c_s), .d(d_s), .rnd(rnd), .dec(dec_q),
            .nl(l_n), .nr(r_n), .nc(c_n), .nd(d_n)
        );
    end

    assign last = (cnt == 4'(NITER - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and handshake outputs
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nx = ROUND;
            end
            ROUND:   if (last) state_nx = ROUND == state ? DONE : state;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand load, round iteration and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_q      <= '0;
            r_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            cnt      <= '0;
            dec_q    <= 1'b0;
            out_data <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    {l_q, r_q} <= perm_ip(in_data);
                    {c_q, d_q} <= perm_pc1(key);
                    dec_q      <= decrypt;
                    cnt        <= '0;
                end
                ROUND: begin
                    l_q <= g_rnd[RPC-1].l_n;
                    r_q <= g_rnd[RPC-1].r_n;
                    c_q <= g_rnd[RPC-1].c_n;
                    d_q <= g_rnd[RPC-1].d_n;
                    cnt <= cnt + 4'd1;
                    if (last) out_data <= perm_fp({g_rnd[RPC-1].r_n, g_rnd[RPC-1].l_n});
                end
                default: ;
            endcase
        end
    end
endmodule
